// File: rtl/hilo_mdu_sequencer_pkg.sv
// Shared opcode encodings, state/accumulate enums and the HI/LO type for the
// multiply/divide-unit sequencer.
package mdu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned HILO_W = 2 * XLEN;
  localparam int unsigned OP_W   = 5;

  localparam logic [OP_W-1:0] OP_MULT  = 5'b00011;
  localparam logic [OP_W-1:0] OP_MULTU = 5'b00100;
  localparam logic [OP_W-1:0] OP_MADD  = 5'b10100;
  localparam logic [OP_W-1:0] OP_MSUB  = 5'b10101;
  localparam logic [OP_W-1:0] OP_MFHI  = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFLO  = 5'b11000;
  localparam logic [OP_W-1:0] OP_MTHI  = 5'b11001;
  localparam logic [OP_W-1:0] OP_MTLO  = 5'b11010;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_mode_t;
  typedef logic [HILO_W-1:0] hilo_t;

  // Absolute value of a two's-complement operand; unsigned operands pass through.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/hilo_mdu_sequencer_if.sv
// Request/response bundle between decode/execute and the HI/LO sequencer.
interface hilo_mdu_sequencer_if;
  import mdu_pkg::*;

  logic                ReqValid;
  logic                ReqReady;
  logic [OP_W-1:0]     ReqOp;
  logic [XLEN-1:0]     A;
  logic [XLEN-1:0]     B;
  logic                Flush;
  logic                RdValid;
  logic [XLEN-1:0]     RdData;
  logic                Busy;
  hilo_t               HiLo;
  logic                IllegalOp;

  modport master (
    output ReqValid, ReqOp, A, B, Flush,
    input  ReqReady, RdValid, RdData, Busy, HiLo, IllegalOp
  );

  modport slave (
    input  ReqValid, ReqOp, A, B, Flush,
    output ReqReady, RdValid, RdData, Busy, HiLo, IllegalOp
  );

endinterface

// File: rtl/hilo_mdu_sequencer_iter_mul.sv
// Iterative unsigned shift-add multiplier retiring ITER_BITS multiplier bits per
// cycle; done is high during the final iteration cycle.
module mdu_iter_mul
  import mdu_pkg::*;
#(
  parameter int unsigned ITER_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            iterate,
  input  logic [XLEN-1:0] mag_a,
  input  logic [XLEN-1:0] mag_b,
  output logic            done,
  output hilo_t           product
);

  localparam int unsigned N     = XLEN / ITER_BITS;
  localparam int unsigned CNT_W = $clog2(N + 1);

  hilo_t              mcand_q;
  logic [XLEN-1:0]    mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  hilo_t              partial_c;

  // Sum of the ITER_BITS partial products selected by the low multiplier digit.
  always_comb begin
    partial_c = mcand_q * HILO_W'(mplier_q[ITER_BITS-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done     <= 1'b0;
      product  <= '0;
    end else if (start) begin
      mcand_q  <= HILO_W'(mag_a);
      mplier_q <= mag_b;
      cnt_q    <= '0;
      done     <= 1'b0;
      product  <= '0;
    end else if (iterate) begin
      product  <= product + partial_c;
      mcand_q  <= mcand_q << ITER_BITS;
      mplier_q <= mplier_q >> ITER_BITS;
      cnt_q    <= cnt_q + CNT_W'(1);
      // Registered look-ahead so done coincides with the last iteration cycle.
      done     <= (cnt_q == CNT_W'(N - 2));
    end
  end

endmodule

// File: rtl/hilo_mdu_sequencer.sv
// HI/LO multiply sequencer: owns {HI,LO}, runs MULT/MULTU (and MADD/MSUB when
// HILO_ACCUM_EN is defined) iteratively, and serves MTHI/MTLO/MFHI/MFLO in IDLE.
module hilo_mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned ITER_BITS = 1
) (
  input logic                 Clk,
  input logic                 Rst_n,
  hilo_mdu_sequencer_if.slave bus
);

  state_t          state_q, state_d;
  hilo_t           hilo_q, hilo_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            illegal_q, illegal_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            neg_q, neg_d;
`ifdef HILO_ACCUM_EN
  acc_mode_t       acc_mode_q, acc_mode_d, acc_mode_c;
`endif

  logic            accept_c;
  logic            is_mul_c;
  logic            is_signed_c;
  logic [XLEN-1:0] mag_a_c, mag_b_c;
  logic            mul_start_c;
  logic            mul_iter_c;
  logic            mul_done;
  hilo_t           mul_product;
  hilo_t           signed_prod_c;
  hilo_t           commit_c;

  assign accept_c = bus.ReqValid & ready_q & ~bus.Flush;
  assign mag_a_c  = magnitude(bus.A, is_signed_c);
  assign mag_b_c  = magnitude(bus.B, is_signed_c);

  // Opcode decode for the multiply class.
  always_comb begin
    is_mul_c    = 1'b0;
    is_signed_c = 1'b0;
`ifdef HILO_ACCUM_EN
    acc_mode_c  = ACC_NONE;
`endif
    case (bus.ReqOp)
      OP_MULT: begin
        is_mul_c    = 1'b1;
        is_signed_c = 1'b1;
      end
      OP_MULTU: is_mul_c = 1'b1;
`ifdef HILO_ACCUM_EN
      OP_MADD: begin
        is_mul_c    = 1'b1;
        is_signed_c = 1'b1;
        acc_mode_c  = ACC_ADD;
      end
      OP_MSUB: begin
        is_mul_c    = 1'b1;
        is_signed_c = 1'b1;
        acc_mode_c  = ACC_SUB;
      end
`endif
      default: ;
    endcase
  end

  mdu_iter_mul #(
    .ITER_BITS (ITER_BITS)
  ) u_iter_mul (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .start   (mul_start_c),
    .iterate (mul_iter_c),
    .mag_a   (mag_a_c),
    .mag_b   (mag_b_c),
    .done    (mul_done),
    .product (mul_product)
  );

  // Sign correction and optional accumulate applied in FIX.
  always_comb begin
    signed_prod_c = neg_q ? (~mul_product + HILO_W'(1)) : mul_product;
`ifdef HILO_ACCUM_EN
    case (acc_mode_q)
      ACC_ADD: commit_c = hilo_q + signed_prod_c;
      ACC_SUB: commit_c = hilo_q - signed_prod_c;
      default: commit_c = signed_prod_c;
    endcase
`else
    commit_c = signed_prod_c;
`endif
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; Flush aborts ITER and FIX.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_c && is_mul_c) state_d = ITER;
      ITER: begin
        if (bus.Flush)     state_d = IDLE;
        else if (mul_done) state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    hilo_d      = hilo_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    illegal_d   = 1'b0;
    neg_d       = neg_q;
    mul_start_c = 1'b0;
    mul_iter_c  = 1'b0;
    busy_d      = (state_d != IDLE);
    ready_d     = (state_d == IDLE);
`ifdef HILO_ACCUM_EN
    acc_mode_d  = acc_mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (is_mul_c) begin
            mul_start_c = 1'b1;
            neg_d       = is_signed_c & (bus.A[XLEN-1] ^ bus.B[XLEN-1]);
`ifdef HILO_ACCUM_EN
            acc_mode_d  = acc_mode_c;
`endif
          end else begin
            case (bus.ReqOp)
              OP_MTHI: hilo_d[HILO_W-1:XLEN] = bus.A;
              OP_MTLO: hilo_d[XLEN-1:0]      = bus.A;
              OP_MFHI: begin
                rd_data_d  = hilo_q[HILO_W-1:XLEN];
                rd_valid_d = 1'b1;
              end
              OP_MFLO: begin
                rd_data_d  = hilo_q[XLEN-1:0];
                rd_valid_d = 1'b1;
              end
              default: illegal_d = 1'b1;
            endcase
          end
        end
      end
      ITER:    mul_iter_c = ~bus.Flush;
      FIX:     if (!bus.Flush) hilo_d = commit_c;
      default: ;
    endcase
  end

  // Output and context registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hilo_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      neg_q      <= 1'b0;
`ifdef HILO_ACCUM_EN
      acc_mode_q <= ACC_NONE;
`endif
    end else begin
      hilo_q     <= hilo_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      illegal_q  <= illegal_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      neg_q      <= neg_d;
`ifdef HILO_ACCUM_EN
      acc_mode_q <= acc_mode_d;
`endif
    end
  end

  assign bus.ReqReady  = ready_q;
  assign bus.RdValid   = rd_valid_q;
  assign bus.RdData    = rd_data_q;
  assign bus.Busy      = busy_q;
  assign bus.HiLo      = hilo_q;
  assign bus.IllegalOp = illegal_q;

endmodule

// File: tb/tb_hilo_mdu_sequencer.sv
// Scoreboard bench for hilo_mdu_sequencer: the driver pushes time-stamped
// expectations from a 64-bit arithmetic model; a negedge monitor checks them.
module tb_hilo_mdu_sequencer;
  import mdu_pkg::*;

  localparam int TB_ITER_BITS = 1;
  localparam int N            = 32 / TB_ITER_BITS;
  localparam int K_HILO       = 0;
  localparam int K_RD         = 1;
  localparam int K_ILL        = 2;
  localparam int K_RDDATA     = 3;

  typedef struct {
    int          due;
    int          kind;
    logic [63:0] val;
  } exp_t;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;

  hilo_mdu_sequencer_if bus ();

  hilo_mdu_sequencer #(.ITER_BITS(TB_ITER_BITS)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  exp_t        scb[$];
  int          checks    = 0;
  int          errors    = 0;
  bit          mon_en    = 1'b0;
  int          busy_from = 1;
  int          busy_to   = 0;
  logic [63:0] hilo_m    = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int due, input int kind, input logic [63:0] v);
    scb.push_back('{due: due, kind: kind, val: v});
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference model: which ops run through the multiplier, and their result.
  function automatic bit m_is_mul(input logic [4:0] op);
    case (op)
      OP_MULT, OP_MULTU: return 1'b1;
`ifdef HILO_ACCUM_EN
      OP_MADD, OP_MSUB:  return 1'b1;
`endif
      default:           return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] m_mul(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    logic signed [63:0] sa, sbv, sp;
    logic [63:0] up;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    sp  = sa * sbv;
    up  = {32'd0, a} * {32'd0, b};
    case (op)
      OP_MULTU: return up;
      OP_MADD:  return hl + sp;
      OP_MSUB:  return hl - sp;
      default:  return sp;
    endcase
  endfunction

  // Monitor: consume expectations due this cycle, police unexpected pulses.
  always @(negedge Clk) begin : monitor
    bit   got_rd, got_ill, exp_busy;
    exp_t e;
    if (mon_en) begin
      got_rd  = 1'b0;
      got_ill = 1'b0;
      while (scb.size() > 0 && scb[0].due <= cyc) begin
        e = scb.pop_front();
        if (e.due < cyc) begin
          checks++;
          errors++;
          $display("FAIL stale_expectation: due cycle %0d seen at cycle %0d", e.due, cyc);
        end else begin
          case (e.kind)
            K_HILO: check("hilo", bus.HiLo, e.val);
            K_RD: begin
              got_rd = 1'b1;
              check("rd_valid", 64'(bus.RdValid), 64'd1);
              check("rd_data", 64'(bus.RdData), e.val);
            end
            K_ILL: begin
              got_ill = 1'b1;
              check("illegal_op", 64'(bus.IllegalOp), 64'd1);
            end
            default: check("rd_data_hold", 64'(bus.RdData), e.val);
          endcase
        end
      end
      if (!got_rd)  check("rd_valid_quiet", 64'(bus.RdValid), 64'd0);
      if (!got_ill) check("illegal_quiet", 64'(bus.IllegalOp), 64'd0);
      exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
      check("busy", 64'(bus.Busy), 64'(exp_busy));
      check("req_ready", 64'(bus.ReqReady), 64'(!exp_busy));
    end
  end

  // Issue one request in the current cycle; multiplies run to completion while
  // optionally presenting junk requests that must not be accepted.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit garbage);
    int c;
    logic [63:0] nv;
    c = cyc;
    bus.ReqValid = 1'b1;
    bus.ReqOp    = op;
    bus.A        = a;
    bus.B        = b;
    bus.Flush    = 1'b0;
    if (m_is_mul(op)) begin
      nv        = m_mul(op, a, b, hilo_m);
      busy_from = c + 1;
      busy_to   = c + N + 1;
      push(c + N + 1, K_HILO, hilo_m);
      push(c + N + 2, K_HILO, nv);
      tick();
      for (int k = 0; k <= N; k++) begin
        bus.ReqValid = garbage ? 1'($urandom) : 1'b0;
        bus.ReqOp    = 5'($urandom);
        bus.A        = $urandom;
        bus.B        = $urandom;
        tick();
      end
      hilo_m = nv;
    end else begin
      case (op)
        OP_MTHI: hilo_m[63:32] = a;
        OP_MTLO: hilo_m[31:0]  = a;
        OP_MFHI: push(c + 1, K_RD, {32'd0, hilo_m[63:32]});
        OP_MFLO: push(c + 1, K_RD, {32'd0, hilo_m[31:0]});
        default: push(c + 1, K_ILL, 64'd0);
      endcase
      push(c + 1, K_HILO, hilo_m);
      tick();
    end
    bus.ReqValid = 1'b0;
  endtask

  // Multiply flushed `at` cycles after acceptance (at == N lands in FIX).
  task automatic issue_flush(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int at);
    int c;
    c = cyc;
    bus.ReqValid = 1'b1;
    bus.ReqOp    = op;
    bus.A        = a;
    bus.B        = b;
    bus.Flush    = 1'b0;
    busy_from    = c + 1;
    busy_to      = c + 1 + at;
    push(c + 2 + at, K_HILO, hilo_m);
    tick();
    bus.ReqValid = 1'b0;
    repeat (at) tick();
    bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
  endtask

  // Request presented together with Flush in IDLE: must be dropped.
  task automatic idle_flush(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int c;
    c = cyc;
    bus.ReqValid = 1'b1;
    bus.ReqOp    = op;
    bus.A        = a;
    bus.B        = b;
    bus.Flush    = 1'b1;
    push(c + 1, K_HILO, hilo_m);
    tick();
    bus.Flush    = 1'b0;
    bus.ReqValid = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin : driver
    int c;
    bus.ReqValid = 1'b0;
    bus.ReqOp    = '0;
    bus.A        = '0;
    bus.B        = '0;
    bus.Flush    = 1'b0;
    repeat (3) tick();
    Rst_n  = 1'b1;
    mon_en = 1'b1;
    push(cyc, K_HILO, 64'd0);
    push(cyc, K_RDDATA, 64'd0);

    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(OP_MFHI, 32'd0, 32'd0, 1'b0);
    issue(OP_MTHI, 32'd1, 32'd0, 1'b0);
    issue(OP_MTLO, 32'd0, 32'd0, 1'b0);
    issue(OP_MADD, 32'h8000_0000, 32'd2, 1'b0);
    issue(OP_MTHI, 32'd0, 32'd0, 1'b0);
    issue(OP_MTLO, 32'd0, 32'd0, 1'b0);
    issue(OP_MSUB, 32'd5, 32'd7, 1'b0);
    issue(OP_MFLO, 32'd0, 32'd0, 1'b0);

    issue(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    issue_flush(OP_MULT, 32'h0000_0777, 32'h0000_0555, 10);
    issue(OP_MFLO, 32'd0, 32'd0, 1'b0);
    issue_flush(OP_MULTU, 32'hFFFF_0000, 32'h0000_FFFF, N);
    idle_flush(OP_MTHI, 32'h1234_5678, 32'd0);
    idle_flush(OP_MFHI, 32'd0, 32'd0);
    idle_flush(OP_MULT, 32'd9, 32'd9);
    issue(5'b11111, 32'd1, 32'd2, 1'b0);
    issue(5'b00000, 32'd3, 32'd4, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      int          r;
      r = int'($urandom_range(0, 9));
      case (r)
        0:       op = OP_MULT;
        1:       op = OP_MULTU;
        2:       op = OP_MADD;
        3:       op = OP_MSUB;
        4:       op = OP_MFHI;
        5:       op = OP_MFLO;
        6:       op = OP_MTHI;
        7:       op = OP_MTLO;
        default: op = 5'($urandom);
      endcase
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) idle_flush(op, a, b);
      else                           issue(op, a, b, 1'($urandom));
    end

    issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
    issue(OP_MFHI, 32'd0, 32'd0, 1'b0);

    // Asynchronous reset in the middle of a multiply.
    c = cyc;
    bus.ReqValid = 1'b1;
    bus.ReqOp    = OP_MULT;
    bus.A        = 32'h0001_0001;
    bus.B        = 32'h0000_0003;
    busy_from    = c + 1;
    busy_to      = c + 4;
    tick();
    bus.ReqValid = 1'b0;
    repeat (4) tick();
    Rst_n  = 1'b0;
    hilo_m = '0;
    push(c + 5, K_HILO, 64'd0);
    push(c + 5, K_RDDATA, 64'd0);
    tick();
    Rst_n = 1'b1;
    tick();
    issue(OP_MULT, 32'd6, 32'd7, 1'b0);
    issue(OP_MFLO, 32'd0, 32'd0, 1'b0);

    repeat (3) tick();
    checks++;
    if (scb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", scb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_mdu_sequencer.md
# hilo_mdu_sequencer

Multi-cycle multiply/divide-unit sequencer that owns the architectural HI/LO register pair and executes the HI/LO-class operations (MULT, MULTU, MADD, MSUB, MTHI, MTLO, MFHI, MFLO) off the single-cycle ALU path. It sits beside the ALU in the execute stage, takes requests from decode through a valid/ready handshake, runs an iterative shift-add multiplier, and stalls the pipeline while busy. It is the sole writer of HI/LO.

## Interface
- `ITER_BITS`, default 1: multiplier bits retired per cycle; legal values 1, 2, 4; iteration count `N = 32/ITER_BITS`.
- `Clk` in, 1: clock, rising edge.
- `Rst_n` in, 1: asynchronous, active-low reset.
- `ReqValid` in, 1: request present.
- `ReqReady` out, 1: sequencer accepts a request this cycle.
- `ReqOp` in, 5: operation in ALU control encoding: MULT 00011, MULTU 00100, MADD 10100, MSUB 10101, MFHI 10111, MFLO 11000, MTHI 11001, MTLO 11010.
- `A`, `B` in, 32: operands (rs, rt).
- `Flush` in, 1: abort the operation in flight.
- `RdValid` out, 1: one-cycle pulse, `RdData` valid.
- `RdData` out, 32: MFHI/MFLO result.
- `Busy` out, 1: multiply in flight, drives pipeline stall.
- `HiLo` out, 64: architectural {HI, LO}.
- `IllegalOp` out, 1: one-cycle pulse on an accepted unsupported opcode.

## Operation
- A request is accepted on `ReqValid & ReqReady & ~Flush`. `ReqReady` = (state == IDLE).
- States and transitions:
  - IDLE: a multiply-class op loads the operand registers and goes to ITER.
  - ITER: `N` cycles; each cycle adds `ITER_BITS` partial products into a 64-bit accumulator. Goes to FIX after the last iteration.
  - FIX: one cycle. Applies sign correction, the accumulate/subtract, and commits HiLo. Goes to IDLE.
- Signed ops (MULT, MADD, MSUB) run on operand magnitudes. The 64-bit product is two's-complement negated when `A[31]^B[31]`.
- MULTU treats operands as unsigned.
- Commit values in FIX:
  - MULT/MULTU: HiLo = P.
  - MADD: HiLo = HiLo + P.
  - MSUB: HiLo = HiLo − P.
  - All arithmetic is modulo 2^64; no overflow flag.
- Ops handled in IDLE without leaving IDLE:
  - MTHI: HI = A; LO unchanged.
  - MTLO: LO = A; HI unchanged.
  - MFHI/MFLO: `RdData` = HI/LO, `RdValid` pulses the next cycle.
- Any other opcode, when accepted: `IllegalOp` pulses the next cycle and state is unchanged.
- Flush:
  - In ITER/FIX: aborts, returns to IDLE next edge, HiLo unchanged.
  - In IDLE: the same-cycle request is dropped.
  - Flush has priority over the FIX commit.

## Timing
- Reset values: state IDLE, HiLo 0, `RdData` 0, `RdValid` 0, `IllegalOp` 0, `Busy` 0, `ReqReady` 1.
- Multiply-class latency: accepted at edge 0 → HiLo updated at edge N+1. `Busy` is high from the cycle after acceptance through FIX. `ReqReady` is low for the same window.
- With `ITER_BITS`=1, MULT takes 33 cycles from acceptance to commit.
- MTHI/MTLO: HiLo updated at the accepting edge. An MFHI/MFLO issued the next cycle returns the new value.
- Back-to-back IDLE ops are accepted every cycle at full throughput.
- `Rst_n` asserted mid-ITER: immediate return to IDLE, HiLo cleared.

## Configuration
- `HILO_ACCUM_EN` defined: MADD and MSUB are supported as above.
- `HILO_ACCUM_EN` undefined: the accumulate adder/subtractor is compiled out. MADD/MSUB are treated as unsupported opcodes (`IllegalOp` pulse, HiLo unchanged).

## Structure
- Shared package `mdu_pkg`:
  - opcode localparams (the 5-bit encodings above);
  - state enum typedef {IDLE, ITER, FIX};
  - the 64-bit HiLo type.
- One sub-module: `mdu_iter_mul`. It holds the operand registers, the partial-product accumulator and the iteration counter. Ports: start, done, 32-bit magnitudes, 64-bit product.
- Sign correction and accumulate stay in the top level.

## Test plan
- Reset, then MULT A=0xFFFFFFFE (−2), B=3 → HiLo = 0xFFFFFFFF_FFFFFFFA at edge 33; `Busy` high for exactly 33 cycles.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → HiLo = 0xFFFFFFFE_00000001; MFHI next → `RdData` 0xFFFFFFFE, `RdValid` one cycle.
- MTHI 0x1, MTLO 0x0 back-to-back, then MADD A=0x80000000, B=2 → HiLo = 0x00000000_00000000 (wraps); without `HILO_ACCUM_EN` → `IllegalOp` pulse, HiLo stays 0x00000001_00000000.
- MSUB A=5, B=7 from HiLo 0 → HiLo = 0xFFFFFFFF_FFFFFFDD.
- MULT started, `Flush` asserted at iteration 10 → IDLE next cycle, HiLo unchanged, `ReqReady` high; MFLO accepted the next cycle.
- `Rst_n` dropped mid-ITER with `ITER_BITS`=4 → `Busy` 0 and HiLo 0 immediately; a MULT 6×7 after release → HiLo 42 at edge 9.
